// File: rtl/phase_pattern_gen.sv
// ---------------------------------------------------------------------------
// phase_pattern_gen
//
// Sits after the 6-state phase counter. For each sampled phase value it
// drives one programmable pattern word. It also counts completed frames
// (5 -> 0) and, optionally, flags illegal phase sequences.
//
// Optional feature macro: PHASE_SEQ_CHECK_EN
//   defined     : sequence checker compiled in, seq_err is live
//   not defined : checker absent, seq_err tied to 0, err_clr ignored
//
// Parameters
//   DW          pattern word width
//   FCW         frame counter width
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears table and all state)
//   cnt         phase value: 0 idle, 1..5 active, 6/7 illegal
//   wr_en       pattern table write strobe
//   wr_addr     table entry to write (only 1..5 take effect)
//   wr_data     pattern word to write
//   err_clr     clears the sticky seq_err flag
//   pat_out     registered pattern word for the sampled phase
//   pat_valid   high while pat_out holds an active-phase word
//   frame_done  one-cycle pulse per completed frame
//   frame_count saturating count of completed frames
//   seq_err     sticky illegal-transition flag
// ---------------------------------------------------------------------------
module phase_pattern_gen #(
  parameter int DW  = 8,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     cnt,
  input  logic           wr_en,
  input  logic [2:0]     wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           err_clr,
  output logic [DW-1:0]  pat_out,
  output logic           pat_valid,
  output logic           frame_done,
  output logic [FCW-1:0] frame_count,
  output logic           seq_err
);

  logic [DW-1:0]  pat_table_reg [1:5];
  logic [2:0]     cnt_q_reg;
  logic [DW-1:0]  pat_out_reg;
  logic           pat_valid_reg;
  logic           frame_done_reg;
  logic [FCW-1:0] frame_count_reg;

  logic cnt_active;
  logic wr_hit;
  logic frame_evt;

  assign cnt_active = (cnt >= 3'd1) && (cnt <= 3'd5);
  assign wr_hit     = wr_en && (wr_addr >= 3'd1) && (wr_addr <= 3'd5);
  assign frame_evt  = (cnt_q_reg == 3'd5) && (cnt == 3'd0);

  // Pattern table. The read below lives in its own registered process and
  // sees the pre-edge contents, so a same-cycle write to the entry being
  // read returns the old word; the new word shows from the next sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= 5; i++) begin
        pat_table_reg[i] <= '0;
      end
    end else if (wr_hit) begin
      pat_table_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_out_reg   <= '0;
      pat_valid_reg <= 1'b0;
    end else if (cnt_active) begin
      pat_out_reg   <= pat_table_reg[cnt];
      pat_valid_reg <= 1'b1;
    end else begin
      pat_out_reg   <= '0;
      pat_valid_reg <= 1'b0;
    end
  end

  // Previous phase sample plus frame detection and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q_reg       <= 3'd0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      cnt_q_reg      <= cnt;
      frame_done_reg <= frame_evt;
      if (frame_evt && (frame_count_reg != {FCW{1'b1}})) begin
        frame_count_reg <= frame_count_reg + FCW'(1);
      end
    end
  end

  assign pat_out     = pat_out_reg;
  assign pat_valid   = pat_valid_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

`ifdef PHASE_SEQ_CHECK_EN
  logic seq_err_reg;
  logic trans_legal;

  // Only the counter's natural walk 0->0, 0->1, 1->2 .. 4->5, 5->0 is legal;
  // anything touching 6 or 7 falls through to illegal.
  always_comb begin
    trans_legal = 1'b0;
    case (cnt_q_reg)
      3'd0:    trans_legal = (cnt == 3'd0) || (cnt == 3'd1);
      3'd1:    trans_legal = (cnt == 3'd2);
      3'd2:    trans_legal = (cnt == 3'd3);
      3'd3:    trans_legal = (cnt == 3'd4);
      3'd4:    trans_legal = (cnt == 3'd5);
      3'd5:    trans_legal = (cnt == 3'd0);
      default: trans_legal = 1'b0;
    endcase
  end

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_reg <= 1'b0;
    end else if (!trans_legal) begin
      seq_err_reg <= 1'b1;
    end else if (err_clr) begin
      seq_err_reg <= 1'b0;
    end
  end

  assign seq_err = seq_err_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_phase_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_phase_pattern_gen
//
// Two instances share one stimulus stream: dut8 (FCW=8) and dut2 (FCW=2,
// exercises counter saturation). A directed vector table, a few hand-written
// corner sequences and a randomized run are checked against a behavioural
// model that works from the transition rules directly.
// ---------------------------------------------------------------------------
module tb_phase_pattern_gen;

  localparam int DW = 8;
`ifdef PHASE_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cnt;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          err_clr;

  logic [DW-1:0] pat_out8, pat_out2;
  logic          pat_valid8, pat_valid2;
  logic          frame_done8, frame_done2;
  logic [7:0]    frame_count8;
  logic [1:0]    frame_count2;
  logic          seq_err8, seq_err2;

  always #5 clk = ~clk;

  phase_pattern_gen #(.DW(DW), .FCW(8)) dut8 (
    .clk(clk), .rst(rst), .cnt(cnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err_clr(err_clr), .pat_out(pat_out8),
    .pat_valid(pat_valid8), .frame_done(frame_done8),
    .frame_count(frame_count8), .seq_err(seq_err8)
  );

  phase_pattern_gen #(.DW(DW), .FCW(2)) dut2 (
    .clk(clk), .rst(rst), .cnt(cnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .err_clr(err_clr), .pat_out(pat_out2),
    .pat_valid(pat_valid2), .frame_done(frame_done2),
    .frame_count(frame_count2), .seq_err(seq_err2)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  int m_tbl [1:5];
  int m_cq, m_pat, m_valid, m_done, m_fc8, m_fc2, m_err;
  int legal_from [7] = '{0, 0, 1, 2, 3, 4, 5};
  int legal_to   [7] = '{0, 1, 2, 3, 4, 5, 0};

  function automatic bit is_legal(int a, int b);
    for (int i = 0; i < 7; i++) begin
      if (legal_from[i] == a && legal_to[i] == b) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_update();
    int c;
    c = int'(cnt);
    if (rst) begin
      for (int i = 1; i <= 5; i++) m_tbl[i] = 0;
      m_cq = 0; m_pat = 0; m_valid = 0; m_done = 0;
      m_fc8 = 0; m_fc2 = 0; m_err = 0;
    end else begin
      if (c >= 1 && c <= 5) begin
        m_pat = m_tbl[c]; m_valid = 1;
      end else begin
        m_pat = 0; m_valid = 0;
      end
      if (wr_en && wr_addr >= 1 && wr_addr <= 5) m_tbl[int'(wr_addr)] = int'(wr_data);
      m_done = (m_cq == 5 && c == 0) ? 1 : 0;
      if (m_done == 1) begin
        if (m_fc8 < 255) m_fc8++;
        if (m_fc2 < 3)   m_fc2++;
      end
      if (CHK) begin
        if (!is_legal(m_cq, c)) m_err = 1;
        else if (err_clr)       m_err = 0;
      end
      m_cq = c;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pat_out8",     32'(pat_out8),     32'(m_pat));
    chk("pat_valid8",   32'(pat_valid8),   32'(m_valid));
    chk("frame_done8",  32'(frame_done8),  32'(m_done));
    chk("frame_count8", 32'(frame_count8), 32'(m_fc8));
    chk("seq_err8",     32'(seq_err8),     32'(m_err));
    chk("pat_out2",     32'(pat_out2),     32'(m_pat));
    chk("frame_done2",  32'(frame_done2),  32'(m_done));
    chk("frame_count2", 32'(frame_count2), 32'(m_fc2));
    chk("seq_err2",     32'(seq_err2),     32'(m_err));
  endtask

  // One transaction: drive, clock, update model, sample 1 time unit later.
  task automatic step(input bit r, input int c, input bit we, input int wa,
                      input int wd, input bit ec);
    rst = r; cnt = 3'(c); wr_en = we; wr_addr = 3'(wa);
    wr_data = DW'(wd); err_clr = ec;
    @(posedge clk);
    model_update();
    #1;
    $display("txn t=%0t rst=%0d cnt=%0d we=%0d wa=%0d wd=%02h clr=%0d | pat=%02h v=%0d done=%0d fc=%0d err=%0d",
             $time, r, c, we, wa, wd, ec, pat_out8, pat_valid8, frame_done8,
             frame_count8, seq_err8);
  endtask

  task automatic phase(input int c);
    step(1'b0, c, 1'b0, 0, 0, 1'b0);
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; int c; bit we; int wa; int wd;
    int e_pat; bit e_valid; bit e_done; int e_fc;
  } vec_t;

  vec_t vecs [14];

  int next_c, c_cur, pulses;
  int fc_seq [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1; cnt = 3'd0; wr_en = 1'b0; wr_addr = 3'd0;
    wr_data = '0; err_clr = 1'b0;

    vecs[0] = '{1'b1, 0, 1'b0, 0, 0,     0, 1'b0, 1'b0, 0};
    for (int i = 1; i <= 5; i++)
      vecs[i] = '{1'b0, 0, 1'b1, i, 'h11 * i, 0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 0, 1'b0, 0, 0, 0,    1'b0, 1'b0, 0};
    vecs[7]  = '{1'b0, 1, 1'b0, 0, 0, 'h11, 1'b1, 1'b0, 0};
    vecs[8]  = '{1'b0, 2, 1'b0, 0, 0, 'h22, 1'b1, 1'b0, 0};
    vecs[9]  = '{1'b0, 3, 1'b0, 0, 0, 'h33, 1'b1, 1'b0, 0};
    vecs[10] = '{1'b0, 4, 1'b0, 0, 0, 'h44, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b0, 5, 1'b0, 0, 0, 'h55, 1'b1, 1'b0, 0};
    vecs[12] = '{1'b0, 0, 1'b0, 0, 0, 0,    1'b0, 1'b1, 1};
    vecs[13] = '{1'b0, 0, 1'b0, 0, 0, 0,    1'b0, 1'b0, 1};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r, vecs[i].c, vecs[i].we, vecs[i].wa, vecs[i].wd, 1'b0);
      chk($sformatf("vec%0d_pat", i),   32'(pat_out8),     32'(vecs[i].e_pat));
      chk($sformatf("vec%0d_valid", i), 32'(pat_valid8),   32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_done", i),  32'(frame_done8),  32'(vecs[i].e_done));
      chk($sformatf("vec%0d_fc", i),    32'(frame_count8), 32'(vecs[i].e_fc));
      chk($sformatf("vec%0d_err", i),   32'(seq_err8),     32'd0);
    end

    // ---- read/write collision and ignored addresses ----
    phase(1); phase(2);
    step(1'b0, 3, 1'b1, 3, 'hA5, 1'b0);
    check_model();
    chk("collision_old", 32'(pat_out8), 32'h33);
    phase(4); phase(5); phase(0);
    step(1'b0, 0, 1'b1, 0, 'hFF, 1'b0); check_model();
    step(1'b0, 0, 1'b1, 6, 'hFF, 1'b0); check_model();
    step(1'b0, 0, 1'b1, 7, 'hFF, 1'b0); check_model();
    phase(1);
    chk("ignored_wr_p1", 32'(pat_out8), 32'h11);
    phase(2); phase(3);
    chk("collision_new", 32'(pat_out8), 32'hA5);
    phase(4); phase(5);
    chk("ignored_wr_p5", 32'(pat_out8), 32'h55);
    phase(0);

    // ---- sequence checker: set, sticky, clear, set-beats-clear ----
    phase(0); phase(1); phase(3);
    chk("seq_err_set", 32'(seq_err8), 32'(CHK));
    phase(4);
    chk("seq_err_sticky", 32'(seq_err8), 32'(CHK));
    step(1'b0, 5, 1'b0, 0, 0, 1'b1); check_model();
    chk("seq_err_cleared", 32'(seq_err8), 32'd0);
    phase(0); phase(1); phase(2); phase(3);
    step(1'b0, 6, 1'b0, 0, 0, 1'b1); check_model();
    chk("seq_err_set_wins", 32'(seq_err8), 32'(CHK));
    chk("p6_invalid", 32'(pat_valid8), 32'd0);
    step(1'b0, 0, 1'b0, 0, 0, 1'b1); check_model();
    step(1'b0, 0, 1'b0, 0, 0, 1'b1); check_model();

    // ---- FCW=2 saturation over 5 frames ----
    step(1'b1, 0, 1'b0, 0, 0, 1'b0); check_model();
    pulses = 0;
    for (int f = 0; f < 5; f++) begin
      for (int p = 1; p <= 5; p++) begin
        phase(p);
        if (frame_done2) pulses++;
      end
      phase(0);
      if (frame_done2) pulses++;
      chk($sformatf("fc2_frame%0d", f), 32'(frame_count2), 32'(fc_seq[f]));
    end
    chk("fc2_pulses", 32'(pulses), 32'd5);
    chk("fc8_after5", 32'(frame_count8), 32'd5);

    // ---- reset mid-frame ----
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 0, 1'b1, i, 'h10 + i, 1'b0); check_model();
    end
    phase(1); phase(2); phase(3); phase(4);
    step(1'b1, 4, 1'b0, 0, 0, 1'b0); check_model();
    chk("rst_pat",   32'(pat_out8),     32'd0);
    chk("rst_valid", 32'(pat_valid8),   32'd0);
    chk("rst_fc",    32'(frame_count8), 32'd0);
    phase(5);
    chk("post_rst_err", 32'(seq_err8), 32'(CHK));
    chk("post_rst_pat", 32'(pat_out8), 32'd0);
    phase(0); phase(1);
    chk("table_cleared", 32'(pat_out8), 32'd0);

    // ---- illegal value 7 ----
    step(1'b1, 0, 1'b0, 0, 0, 1'b0); check_model();
    phase(7);
    chk("cnt7_valid", 32'(pat_valid8), 32'd0);
    chk("cnt7_pat",   32'(pat_out8),   32'd0);
    chk("cnt7_err",   32'(seq_err8),   32'(CHK));

    // ---- randomized run ----
    step(1'b1, 0, 1'b0, 0, 0, 1'b0); check_model();
    c_cur = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 88) next_c = (c_cur == 0) ? int'($urandom_range(1)) :
                                            (c_cur >= 5) ? 0 : c_cur + 1;
      else next_c = int'($urandom_range(7));
      step(($urandom_range(99) < 2), next_c, ($urandom_range(99) < 30),
           int'($urandom_range(7)), int'($urandom_range(255)),
           ($urandom_range(99) < 10));
      check_model();
      c_cur = next_c;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_pattern_gen.md
# phase_pattern_gen

Downstream consumer of the 6-state phase counter: takes the 3-bit phase value (0 = idle, 1..5 = active phases), drives a programmable per-phase output pattern, counts completed frames and flags illegal phase sequences. It sits directly after the phase counter and feeds the datapath that needs one pattern word per phase.

## Interface
- `DW`, 8, width of each pattern word and of `pat_out`
- `FCW`, 8, width of the frame counter
- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-high reset
- `cnt` input 3: phase value from the phase counter (0 idle, 1..5 active; 6, 7 illegal)
- `wr_en` input 1: pattern-table write strobe
- `wr_addr` input 3: table entry to write; only 1..5 are valid
- `wr_data` input DW: pattern word to write
- `err_clr` input 1: clears `seq_err`
- `pat_out` output DW: registered pattern word for the sampled phase
- `pat_valid` output 1: high when `pat_out` holds an active-phase word
- `frame_done` output 1: one-cycle pulse per completed frame
- `frame_count` output FCW: saturating count of completed frames
- `seq_err` output 1: sticky illegal-transition flag

One clock; reset is synchronous and active-high.

## Operation
- Pattern table: 5 entries of DW bits, indexed 1..5. Writes with `wr_addr` of 0, 6 or 7 are ignored.
- Per cycle, `cnt` is sampled:
  - If `cnt` is 1..5: `pat_out` <= table[`cnt`] and `pat_valid` <= 1.
  - If `cnt` is 0, 6 or 7: `pat_out` <= 0 and `pat_valid` <= 0.
- Read/write collision: if a write and a read hit the same entry in the same cycle, `pat_out` takes the old entry value. The new value is visible from the next sample.
- `cnt_q` holds the previous sample of `cnt`.
- Frame completion: when `cnt_q`==5 and `cnt`==0, the block registers `frame_done`=1 for one cycle and increments `frame_count`.
  - `frame_count` saturates at 2^FCW-1; it does not wrap.
- Sequence checker (see Configuration):
  - Legal transitions (`cnt_q`->`cnt`): 0->0, 0->1, 1->2, 2->3, 3->4, 4->5, 5->0. Any other transition sets `seq_err`.
  - Any transition into or out of 6 or 7 is illegal.
  - `seq_err` is sticky and is cleared by `err_clr`. If a set and a clear occur in the same cycle, the set wins.
  - An error does not alter the pattern, frame or count behaviour.
- Reset: clears all table entries, `cnt_q`, `pat_out`, `pat_valid`, `frame_done`, `frame_count` and `seq_err` to 0. Reset has priority over writes and over all other events.

## Timing
- Reset values: `pat_out`=0, `pat_valid`=0, `frame_done`=0, `frame_count`=0, `seq_err`=0.
- Latency: `cnt` sampled at edge N appears on `pat_out`/`pat_valid` after edge N.
- Frame detection: `frame_done` and the `frame_count` update appear after the same edge that samples `cnt`=0 following 5.
- `seq_err` rises after the edge that samples the offending `cnt`.
- Reset mid-frame: outputs are 0 after the reset edge. The first post-reset comparison uses `cnt_q`=0, so a counter still at 3 is flagged as 0->3.
- Back-to-back frames (5->0->1 with no idle gap) produce one `frame_done` per frame.

## Configuration
- `PHASE_SEQ_CHECK_EN` defined: the sequence checker is compiled in and operates as specified.
- Not defined: the checker logic is absent, `seq_err` is tied to 0 and `err_clr` is ignored. All other behaviour is unchanged.

## Test plan
- Reset, write entries 1..5 = 8'h11,22,33,44,55, then drive `cnt` 0,1,2,3,4,5,0 -> `pat_out` shows 00,11,22,33,44,55,00 one cycle late; `pat_valid` is high for 5 cycles; `frame_done` pulses once; `frame_count`=1; `seq_err`=0.
- Write entry 3 = 8'hA5 in the same cycle that `cnt`=3 is sampled -> `pat_out`=8'h33 that cycle; on the next frame, phase 3 gives 8'hA5. Writes to `wr_addr`=0, 6 and 7 have no effect.
- Drive `cnt` 0,1,3 -> `seq_err`=1 after the edge sampling 3 and stays set. Assert `err_clr` with a legal transition -> `seq_err`=0 next cycle. Assert `err_clr` together with a 3->6 transition -> `seq_err` stays 1.
- With FCW=2, run 5 frames -> `frame_count` reads 1,2,3,3,3 and `frame_done` pulses 5 times.
- Assert `rst` while `cnt`=4 -> all outputs 0 and the table cleared. Release `rst` with `cnt`=5 -> `seq_err`=1 (0->5), `pat_out`=0.
- Build without `PHASE_SEQ_CHECK_EN` and drive `cnt`=7 -> `seq_err` stays 0, `pat_valid`=0, `pat_out`=0.
